avst_pkt_gen: RTL and testbench

//  Avalon-ST packet transmitter: on a start pulse, emits N packets of programmable byte length with a

---
 rtl/avst_pkt_gen.sv | 183 ++++++++++++++++++
 tb/tb_avst_pkt_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_pkt_gen.sv
// avst_pkt_gen: Avalon-ST packet source.
// On a start pulse, sends cfg_num packets of cfg_len bytes each. Byte k of
// packet p carries (seed + p + k) mod 256, with the first symbol in the MSBs.
// The outputs follow full ready/valid backpressure with a ready latency of 0.
// Optional feature macro: AVST_PKT_GEN_IFG_EN. When it is defined, the source
// inserts IFG idle cycles between packets. When it is undefined, packets are
// sent back-to-back.
module avst_pkt_gen #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int CHAN_W  = 128,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int IFG     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_num,
    input  logic [CHAN_W-1:0]  cfg_chan,
    input  logic [7:0]         cfg_seed,
    output logic               busy,
    output logic               done,
    input  logic               avst_out_ready,
    output logic               avst_out_valid,
    output logic               avst_out_startofpacket,
    output logic [DATA_W-1:0]  avst_out_data,
    output logic [EMPTY_W-1:0] avst_out_empty,
    output logic               avst_out_endofpacket,
    output logic [CHAN_W-1:0]  avst_out_channel
);

    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;     // effective length, never 0
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [7:0]         seed_q, seed_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;     // index of the packet being sent
    logic [LEN_W-1:0]   off_q, off_d;     // byte offset of the current beat
    logic               done_q, done_d;
`ifdef AVST_PKT_GEN_IFG_EN
    logic [15:0]        gap_q, gap_d;     // idle cycles still to insert
`endif

    logic [LEN_W-1:0]   remain;
    logic [LEN_W-1:0]   empty_full;
    logic [CNT_W-1:0]   pkt_next;
    logic               is_eop;
    logic               fire;

    // Per-beat datapath terms. The packet ends on the beat that holds the
    // remaining bytes. Using len-off instead of off+BYTES avoids overflow
    // in the LEN_W-wide arithmetic.
    assign remain     = len_q - off_q;
    assign is_eop     = (remain <= LEN_W'(BYTES));
    assign empty_full = LEN_W'(BYTES) - remain;
    assign pkt_next   = pkt_q + CNT_W'(1);
    assign fire       = avst_out_valid && avst_out_ready;

    assign busy                   = (state_q != ST_IDLE);
    assign done                   = done_q;
    assign avst_out_valid         = (state_q == ST_SEND);
    assign avst_out_startofpacket = avst_out_valid && (off_q == '0);
    assign avst_out_endofpacket   = avst_out_valid && is_eop;
    assign avst_out_empty         = avst_out_endofpacket ? empty_full[EMPTY_W-1:0] : '0;
    assign avst_out_channel       = avst_out_valid ? chan_q : '0;

    // Payload pattern. Byte lanes past the end of the packet are driven to 0.
    always_comb begin
        avst_out_data = '0;
        if (avst_out_valid) begin
            for (int i = 0; i < BYTES; i++) begin
                if (LEN_W'(i) < remain) begin
                    avst_out_data[DATA_W-1-8*i -: 8] =
                        seed_q + pkt_q[7:0] + off_q[7:0] + 8'(i);
                end
            end
        end
    end

    // Next-state logic. The FSM starts runs, advances beats on handshakes
    // and sequences from one packet to the next.
    always_comb begin
        // NOTE: every target gets a hold/default value first, so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        chan_d  = chan_q;
        seed_d  = seed_q;
        pkt_d   = pkt_q;
        off_d   = off_q;
        done_d  = 1'b0;
`ifdef AVST_PKT_GEN_IFG_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_num != '0)) begin
                    len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    num_d   = cfg_num;
                    chan_d  = cfg_chan;
                    seed_d  = cfg_seed;
                    pkt_d   = '0;
                    off_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (fire) begin
                    if (is_eop) begin
                        pkt_d = pkt_next;
                        off_d = '0;
                        if (pkt_next == num_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
`ifdef AVST_PKT_GEN_IFG_EN
                            state_d = ST_GAP;
                            gap_d   = 16'(IFG - 1);
`else
                            state_d = ST_SEND;
`endif
                        end
                    end else begin
                        off_d = off_q + LEN_W'(BYTES);
                    end
                end
            end
`ifdef AVST_PKT_GEN_IFG_EN
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 16'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and configuration registers. Reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            num_q   <= '0;
            chan_q  <= '0;
            seed_q  <= '0;
            pkt_q   <= '0;
            off_q   <= '0;
            done_q  <= 1'b0;
`ifdef AVST_PKT_GEN_IFG_EN
            gap_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // values from before the edge, whatever the statement order.
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            chan_q  <= chan_d;
            seed_q  <= seed_d;
            pkt_q   <= pkt_d;
            off_q   <= off_d;
            done_q  <= done_d;
`ifdef AVST_PKT_GEN_IFG_EN
            gap_q   <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_avst_pkt_gen.sv
// tb_avst_pkt_gen: directed bench for avst_pkt_gen.
// Expected values are worked out by hand from the byte pattern (seed+p+k).
module tb_avst_pkt_gen;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int CHAN_W  = 128;
    localparam int LEN_W   = 16;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_num;
    logic [CHAN_W-1:0]  cfg_chan;
    logic [7:0]         cfg_seed;
    logic               busy;
    logic               done;
    logic               avst_out_ready;
    logic               avst_out_valid;
    logic               avst_out_startofpacket;
    logic [DATA_W-1:0]  avst_out_data;
    logic [EMPTY_W-1:0] avst_out_empty;
    logic               avst_out_endofpacket;
    logic [CHAN_W-1:0]  avst_out_channel;

    int total = 0;
    int bad   = 0;

    avst_pkt_gen dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .cfg_len                (cfg_len),
        .cfg_num                (cfg_num),
        .cfg_chan               (cfg_chan),
        .cfg_seed               (cfg_seed),
        .busy                   (busy),
        .done                   (done),
        .avst_out_ready         (avst_out_ready),
        .avst_out_valid         (avst_out_valid),
        .avst_out_startofpacket (avst_out_startofpacket),
        .avst_out_data          (avst_out_data),
        .avst_out_empty         (avst_out_empty),
        .avst_out_endofpacket   (avst_out_endofpacket),
        .avst_out_channel       (avst_out_channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int k);
        return avst_out_data[DATA_W-1-8*k -: 8];
    endfunction

    task automatic start_run(input int len, input int num, input logic [7:0] seed,
                             input logic [CHAN_W-1:0] chan);
        cfg_len  = LEN_W'(len);
        cfg_num  = CNT_W'(num);
        cfg_seed = seed;
        cfg_chan = chan;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Wait a bounded number of cycles for valid.
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!avst_out_valid && n < 10) begin
            tick();
            n++;
        end
        check(tag, DATA_W'(avst_out_valid), DATA_W'(1));
    endtask

    logic [CHAN_W-1:0] ch_a;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] zero_tail;
    logic              stalled_prev;
    logic              done_seen;
    int                hs;

    initial begin
        ch_a           = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5};
        rst_n          = 1'b0;
        start          = 1'b0;
        cfg_len        = '0;
        cfg_num        = '0;
        cfg_chan       = '0;
        cfg_seed       = '0;
        avst_out_ready = 1'b1;
        #12;
        check("rst_valid", DATA_W'(avst_out_valid), '0);
        check("rst_busy",  DATA_W'(busy), '0);
        check("rst_done",  DATA_W'(done), '0);
        check("rst_data",  avst_out_data, '0);
        check("rst_chan",  DATA_W'(avst_out_channel), '0);
        rst_n = 1'b1;
        tick();

        // cfg_num = 0: start ignored
        start_run(64, 0, 8'h10, ch_a);
        check("num0_busy", DATA_W'(busy), '0);
        check("num0_valid", DATA_W'(avst_out_valid), '0);

        // 1) len=64: one full beat
        start_run(64, 1, 8'h10, ch_a);
        check("t1_busy",  DATA_W'(busy), DATA_W'(1));
        check("t1_sop",   DATA_W'(avst_out_startofpacket), DATA_W'(1));
        check("t1_eop",   DATA_W'(avst_out_endofpacket), DATA_W'(1));
        check("t1_empty", DATA_W'(avst_out_empty), '0);
        check("t1_first", DATA_W'(lane(0)), DATA_W'(8'h10));
        check("t1_last",  DATA_W'(avst_out_data[7:0]), DATA_W'(8'h4F));
        check("t1_chan",  DATA_W'(avst_out_channel), DATA_W'(ch_a));
        tick();
        check("t1_done",  DATA_W'(done), DATA_W'(1));
        check("t1_vld0",  DATA_W'(avst_out_valid), '0);
        check("t1_busy0", DATA_W'(busy), '0);
        tick();
        check("t1_done0", DATA_W'(done), '0);

        // 2) len=65: second beat carries one byte
        start_run(65, 1, 8'h00, ch_a);
        check("t2_b0_sop",   DATA_W'(avst_out_startofpacket), DATA_W'(1));
        check("t2_b0_eop",   DATA_W'(avst_out_endofpacket), '0);
        check("t2_b0_empty", DATA_W'(avst_out_empty), '0);
        check("t2_b0_last",  DATA_W'(avst_out_data[7:0]), DATA_W'(8'h3F));
        tick();
        zero_tail = avst_out_data;
        zero_tail[DATA_W-1 -: 8] = 8'h00;
        check("t2_b1_sop",   DATA_W'(avst_out_startofpacket), '0);
        check("t2_b1_eop",   DATA_W'(avst_out_endofpacket), DATA_W'(1));
        check("t2_b1_empty", DATA_W'(avst_out_empty), DATA_W'(63));
        check("t2_b1_first", DATA_W'(lane(0)), DATA_W'(8'h40));
        check("t2_b1_tail",  zero_tail, '0);
        tick();
        check("t2_done", DATA_W'(done), DATA_W'(1));
        tick();

        // len=0 behaves as len=1
        start_run(0, 1, 8'h77, ch_a);
        check("len0_eop",   DATA_W'(avst_out_endofpacket), DATA_W'(1));
        check("len0_empty", DATA_W'(avst_out_empty), DATA_W'(63));
        check("len0_first", DATA_W'(lane(0)), DATA_W'(8'h77));
        check("len0_b1",    DATA_W'(lane(1)), '0);
        tick();
        tick();

        // 3) len=200 with ready toggling 1,0,1,0...
        start_run(200, 1, 8'h20, ch_a);
        hs = 0;
        stalled_prev = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            avst_out_ready = (c % 2 == 0);
            if (stalled_prev) check("t3_stable", avst_out_data, prev_data);
            if (avst_out_valid && avst_out_ready) begin
                check("t3_first", DATA_W'(lane(0)), DATA_W'(8'(8'h20 + 64 * hs)));
                check("t3_sop", DATA_W'(avst_out_startofpacket), DATA_W'(hs == 0));
                check("t3_eop", DATA_W'(avst_out_endofpacket), DATA_W'(hs == 3));
                if (hs == 3) check("t3_empty", DATA_W'(avst_out_empty), DATA_W'(56));
                hs++;
            end
            stalled_prev = avst_out_valid && !avst_out_ready;
            prev_data = avst_out_data;
            tick();
            if (done) done_seen = 1'b1;
        end
        check("t3_hs", DATA_W'(hs), DATA_W'(4));
        check("t3_done", DATA_W'(done_seen), DATA_W'(1));
        avst_out_ready = 1'b1;
        tick();

        // 4/5) len=10, num=3, seed=0xFE; pattern wraps past 0xFF
        start_run(10, 3, 8'hFE, ch_a);
        for (int p = 0; p < 3; p++) begin
            check("t4_valid", DATA_W'(avst_out_valid), DATA_W'(1));
            check("t4_sop",   DATA_W'(avst_out_startofpacket), DATA_W'(1));
            check("t4_eop",   DATA_W'(avst_out_endofpacket), DATA_W'(1));
            check("t4_empty", DATA_W'(avst_out_empty), DATA_W'(54));
            check("t4_first", DATA_W'(lane(0)), DATA_W'(8'(8'hFE + p)));
            check("t4_byte9", DATA_W'(lane(9)), DATA_W'(8'(8'hFE + p + 9)));
            check("t4_byte10", DATA_W'(lane(10)), '0);
            tick();
`ifdef AVST_PKT_GEN_IFG_EN
            if (p < 2) begin
                for (int g = 0; g < 2; g++) begin
                    check("t5_gap", DATA_W'(avst_out_valid), '0);
                    tick();
                end
            end
`endif
        end
        check("t4_done", DATA_W'(done), DATA_W'(1));
        tick();

        // 6) reset during beat 2 of a 4-beat packet
        start_run(256, 1, 8'h05, ch_a);
        tick();
        tick();
        check("t6_beat2", DATA_W'(lane(0)), DATA_W'(8'h85));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", DATA_W'(avst_out_valid), '0);
        check("t6_rst_busy",  DATA_W'(busy), '0);
        check("t6_rst_data",  avst_out_data, '0);
        check("t6_rst_eop",   DATA_W'(avst_out_endofpacket), '0);
        check("t6_rst_chan",  DATA_W'(avst_out_channel), '0);
        tick();
        check("t6_rst_done", DATA_W'(done), '0);
        rst_n = 1'b1;
        tick();
        check("t6_idle", DATA_W'(avst_out_valid), '0);
        check("t6_nodone", DATA_W'(done), '0);

        // fresh run; a start issued mid-run must not disturb it
        start_run(64, 2, 8'h33, ch_a);
        check("t6_p0_first", DATA_W'(lane(0)), DATA_W'(8'h33));
        cfg_len  = 16'd3;
        cfg_num  = 16'd5;
        cfg_seed = 8'h99;
        cfg_chan = '0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_valid("t6_p1_valid");
        check("t6_p1_first", DATA_W'(lane(0)), DATA_W'(8'h34));
        check("t6_p1_empty", DATA_W'(avst_out_empty), '0);
        check("t6_p1_chan",  DATA_W'(avst_out_channel), DATA_W'(ch_a));
        tick();
        check("t6_done", DATA_W'(done), DATA_W'(1));
        check("t6_busy0", DATA_W'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
